// File: rtl/qdiv_arbiter.sv
// rtl/qdiv_arbiter.sv - round-robin arbiter sharing one sequential Q-format divider
module qdiv_arbiter #(
    parameter int N    = 32,
    parameter int Q    = 15,
    parameter int NREQ = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*N-1:0]           req_dividend,
    input  logic [NREQ*N-1:0]           req_divisor,
    output logic [NREQ-1:0]             req_ready,
    output logic                        rsp_valid,
    output logic [$clog2(NREQ)-1:0]     rsp_id,
    output logic [N-1:0]                rsp_quotient,
    output logic                        rsp_dbz,
    output logic                        busy,
    output logic [N-1:0]                div_dividend,
    output logic [N-1:0]                div_divisor,
    output logic                        div_start,
    input  logic [N-1:0]                div_quotient,
    input  logic                        div_complete
);

    localparam int IDW     = $clog2(NREQ);
    localparam int WD_LOAD = N + Q + 4;
    localparam int WDW     = $clog2(WD_LOAD + 1);

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_ZERO
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IDW-1:0]   last_grant;
    logic [WDW-1:0]   wd;

    logic             grant_hit;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   idx_c;
    logic             grant_en;
    logic [N-1:0]     sel_a;
    logic [N-1:0]     sel_b;
    logic             divisor_zero;
    logic             wd_expire;

    // Scan downward so the last hit written is the nearest index after last_grant.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        idx_c     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx_c = IDW'((int'(last_grant) + k) % NREQ);
            if (req_valid[idx_c]) begin
                grant_hit = 1'b1;
                grant_idx = idx_c;
            end
        end
    end

    assign grant_en     = (state == S_IDLE) && div_complete && grant_hit;
    assign req_ready    = grant_en ? (NREQ'(1) << grant_idx) : '0;
    assign sel_a        = req_dividend[grant_idx*N +: N];
    assign sel_b        = req_divisor[grant_idx*N +: N];
    assign divisor_zero = (sel_b[N-2:0] == '0);
    assign wd_expire    = (wd <= WDW'(1));

    always_comb begin
        state_n = state;
        case (state)
            S_SYNC:  if (div_complete) state_n = S_IDLE;
            S_IDLE:  if (grant_en) state_n = divisor_zero ? S_ZERO : S_ISSUE;
            S_ISSUE: state_n = S_WAIT;
            S_WAIT:  if (div_complete || wd_expire) state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            S_ZERO:  state_n = S_IDLE;
            default: state_n = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_SYNC;
            last_grant   <= IDW'(NREQ - 1);
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_quotient <= '0;
            rsp_dbz      <= 1'b0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            wd           <= '0;
            busy         <= 1'b1;
        end else begin
            state     <= state_n;
            busy      <= (state_n != S_IDLE);
            rsp_valid <= 1'b0;
            div_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_en) begin
                        last_grant   <= grant_idx;
                        div_dividend <= sel_a;
                        div_divisor  <= sel_b;
                        if (divisor_zero) begin
                            rsp_valid    <= 1'b1;
                            rsp_id       <= grant_idx;
                            rsp_dbz      <= 1'b1;
                            rsp_quotient <= {sel_a[N-1] ^ sel_b[N-1], {(N-1){1'b1}}};
                        end else begin
                            div_start <= 1'b1;
                        end
                    end
                end
                S_ISSUE: wd <= WDW'(WD_LOAD);
                S_WAIT: begin
                    if (div_complete) begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= last_grant;
                        rsp_quotient <= div_quotient;
                        rsp_dbz      <= 1'b0;
                    end else if (wd_expire) begin
                        // Divider never reported done: fail the request rather than hang.
                        rsp_valid    <= 1'b1;
                        rsp_id       <= last_grant;
                        rsp_quotient <= '0;
                        rsp_dbz      <= 1'b1;
                        wd           <= '0;
                    end else begin
                        wd <= wd - WDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qdiv_arbiter.sv
// tb/tb_qdiv_arbiter.sv - directed self-checking bench for qdiv_arbiter
module tb_qdiv_arbiter;

    localparam int N    = 32;
    localparam int Q    = 15;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*N-1:0] req_dividend = '0;
    logic [NREQ*N-1:0] req_divisor = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [N-1:0]      rsp_quotient;
    logic              rsp_dbz;
    logic              busy;
    logic [N-1:0]      div_dividend;
    logic [N-1:0]      div_divisor;
    logic              div_start;
    logic [N-1:0]      div_quotient = '0;
    logic              div_complete = 1'b1;

    logic              hang = 1'b0;
    int                dcnt = 0;
    int                checks = 0;
    int                passes = 0;

    qdiv_arbiter #(.N(N), .Q(Q), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_quotient (rsp_quotient),
        .rsp_dbz      (rsp_dbz),
        .busy         (busy),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_start    (div_start),
        .div_quotient (div_quotient),
        .div_complete (div_complete)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mag;
        mag = ({33'd0, a[30:0]} << Q) / {33'd0, b[30:0]};
        return {a[31] ^ b[31], mag[30:0]};
    endfunction

    // Divider stand-in with no reset: done level drops after start, rises 46 cycles later.
    always @(posedge clk) begin
        if (div_start) begin
            div_complete <= 1'b0;
            dcnt         <= N + Q - 2;
            div_quotient <= model_q(div_dividend, div_divisor);
        end else if (!div_complete && !hang) begin
            if (dcnt == 0) div_complete <= 1'b1;
            else           dcnt <= dcnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic exp_dbz, input int exp_lat,
                         input string tag);
        int lat;
        int starts;
        bit seen;
        @(negedge clk);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_dividend[id*N +: N] = a;
        req_divisor[id*N +: N]  = b;
        #1;
        chk({tag, "_ready"}, req_ready, 64'(1) << id);
        @(negedge clk);
        req_valid = '0;
        lat = 1;
        starts = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            if (div_start) starts++;
            if (lat == 2 && exp_lat > 2) begin
                req_valid = '1;
                #1;
                chk({tag, "_no_ready_busy"}, req_ready, 0);
                req_valid = '0;
            end
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({tag, "_seen"}, seen, 1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_q"}, rsp_quotient, exp_q);
        chk({tag, "_dbz"}, rsp_dbz, exp_dbz);
        chk({tag, "_starts"}, starts, (exp_lat > 1) ? 1 : 0);
        chk({tag, "_opnd"}, div_dividend, a);
    endtask

    initial begin
        bit seen_rsp;
        bit bad_busy;
        bit got;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_q", rsp_quotient, 0);
        chk("rst_rsp_dbz", rsp_dbz, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_opnd", {div_dividend, div_divisor}, 0);
        req_valid = '1;
        #1;
        chk("rst_no_ready", req_ready, 0);
        req_valid = '0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        do_op(0, 32'h0001_8000, 32'h0000_C000, 32'h0001_0000, 1'b0, 49, "single");
        do_op(1, 32'h8001_8000, 32'h0000_C000, 32'h8001_0000, 1'b0, 49, "sign");
        do_op(3, 32'h0000_8000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1,  "dbz_neg");
        do_op(3, 32'h0002_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1,  "dbz_pos");

        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*N +: N] = 32'((i + 1) << Q);
            req_divisor[i*N +: N]  = 32'h0000_8000;
        end
        @(negedge clk);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            got = 1'b0;
            for (int t = 0; t < 100 && !got; t++) begin
                #1;
                if (req_ready != 0) got = 1'b1;
                else @(negedge clk);
            end
            chk($sformatf("fair_grant%0d", k), req_ready, 64'(1) << (k % NREQ));
            got = 1'b0;
            for (int t = 0; t < 100 && !got; t++) begin
                @(negedge clk);
                if (rsp_valid) got = 1'b1;
            end
            chk($sformatf("fair_rsp%0d", k), {got, 2'b00, rsp_id, rsp_quotient},
                {1'b1, 2'b00, 2'(k % NREQ), 32'(((k % NREQ) + 1) << Q)});
        end
        req_valid = '0;
        repeat (2) @(negedge clk);

        req_dividend[1*N +: N] = 32'h0001_8000;
        req_divisor[1*N +: N]  = 32'h0000_C000;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        chk("mid_start", div_start, 1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {busy, rsp_valid, div_start, div_dividend}, {1'b1, 1'b0, 1'b0, 32'h0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_rsp = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp = 1'b1;
            if (!div_complete && !busy) bad_busy = 1'b1;
        end
        chk("mid_no_rsp", seen_rsp, 0);
        chk("mid_busy_held", bad_busy, 0);
        chk("mid_recovered", {div_complete, busy}, {1'b1, 1'b0});
        do_op(2, 32'h0001_8000, 32'h0000_C000, 32'h0001_0000, 1'b0, 49, "post_rst");

        hang = 1'b1;
        do_op(0, 32'h0001_0000, 32'h0000_8000, 32'h0000_0000, 1'b1, 53, "wdog");
        @(negedge clk);
        chk("wdog_idle", busy, 0);
        hang = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (div_complete) got = 1'b1;
        end
        chk("wdog_div_done", got, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/qdiv_arbiter.md
QDIV_ARBITER -- requirements
Module: qdiv_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/quotient width in sign-magnitude Q format.
REQ-002 SHALL have parameter Q, default 15, meaning fractional bits, passed unchanged to the shared divider.
REQ-003 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  NREQ  per-requester divide request.
REQ-007 req_dividend  in  NREQ*N  flattened dividends; slice i = bits [i*N+N-1 : i*N].
REQ-008 req_divisor  in  NREQ*N  flattened divisors, same slicing.
REQ-009 req_ready  out  NREQ  one-hot accept strobe; transfer when req_valid[i] & req_ready[i].
REQ-010 rsp_valid  out  1  one-cycle result strobe.
REQ-011 rsp_id  out  clog2(NREQ)  index of requester owning the result.
REQ-012 rsp_quotient  out  N  result; held until next rsp_valid.
REQ-013 rsp_dbz  out  1  divide-by-zero flag, qualified by rsp_valid.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 div_dividend, div_divisor  out  N each  operands to shared sequential divider.
REQ-016 div_start  out  1  divider start pulse.
REQ-017 div_quotient  in  N  divider result.
REQ-018 div_complete  in  1  divider idle/done level (high when idle).

Function
REQ-019 SHALL implement FSM states SYNC, IDLE, ISSUE, WAIT, RESP, ZERO.
REQ-020 SYNC: stay until div_complete=1, then IDLE (divider has no reset; arbiter must not start it while busy).
REQ-021 IDLE: if div_complete=1 and any req_valid, grant the first valid index searching from (last_grant+1) mod NREQ upward with wrap; req_ready[g] asserted combinationally that same cycle only.
REQ-022 At grant, SHALL latch operands and g; last_grant <= g.
REQ-023 At grant, if latched divisor bits [N-2:0]=0, next state ZERO, else ISSUE.
REQ-024 ISSUE: div_start=1 for exactly one cycle; next WAIT.
REQ-025 div_dividend/div_divisor SHALL be registered and stable from ISSUE through RESP.
REQ-026 WAIT: exit to RESP on first cycle div_complete=1 (divider drops div_complete the cycle after ISSUE).
REQ-027 WAIT watchdog: counter loaded N+Q+4 on ISSUE; if it reaches 0 before div_complete=1, go RESP with rsp_dbz=1 and rsp_quotient=0.
REQ-028 RESP: rsp_valid=1, rsp_id=g, rsp_quotient=div_quotient, rsp_dbz=0; next IDLE.
REQ-029 ZERO: rsp_valid=1, rsp_id=g, rsp_dbz=1, rsp_quotient={dividend[N-1]^divisor[N-1], all-ones[N-2:0]}; next IDLE.
REQ-030 Latency accept-cycle to rsp_valid: N+Q+2 cycles normal (49 at defaults); 1 cycle for divide-by-zero.
REQ-031 Only one outstanding operation; no req_ready in any state other than IDLE.
REQ-032 Requests withdrawn before grant are dropped without side effect; no grant when req_valid=0.
REQ-033 rsp_valid/rsp_id/rsp_quotient/rsp_dbz/div_* SHALL be registered outputs; req_ready is the only combinational output.

Reset
REQ-034 rst_n=0 SHALL asynchronously force state SYNC, last_grant=NREQ-1, rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_dbz=0, div_start=0, div_dividend=0, div_divisor=0, watchdog=0, busy=1.
REQ-035 Reset mid-operation SHALL discard the in-flight result; no rsp_valid for it; SYNC waits for divider to finish.

Verification
REQ-036 Single: req0 dividend 3.0 (0x00018000), divisor 1.5 (0x0000C000) -> rsp_valid 49 cycles after accept, rsp_id=0, quotient 0x00010000, dbz=0.
REQ-037 Sign: dividend -3.0 (0x80018000), divisor 1.5 -> quotient 0x80010000.
REQ-038 Divide-by-zero: divisor 0x80000000 with dividend 0x00008000 -> rsp_valid 1 cycle after accept, quotient 0xFFFFFFFF, dbz=1, div_start never asserted.
REQ-039 Fairness: all four req_valid held high for 8 ops -> grant order 0,1,2,3,0,1,2,3.
REQ-040 Reset mid-op: rst_n low 10 cycles after start -> no rsp_valid; busy until div_complete=1; next request serviced correctly.
REQ-041 Watchdog: model holds div_complete=0 -> rsp_valid with dbz=1, quotient 0, N+Q+4 cycles after WAIT entry.
